// File: rtl/myip_pkg.sv
// Shared types and constants for the my_ip_v1_0 2-lane dot-product coprocessor.
package myip_pkg;

    localparam int DATA_W  = 32;
    localparam int LANE_W  = 16;
    localparam int N_WORDS = 2;
    localparam int N_LANES = DATA_W / LANE_W;

    typedef enum logic [1:0] {
        READ_INPUTS  = 2'd0,
        COMPUTE      = 2'd1,
        WRITE_OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/myip_dot2_alu.sv
// Combinational 2-lane unsigned 16-bit dot product, sum truncated to 32 bits.
module myip_dot2_alu
    import myip_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] prod [N_LANES];

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign prod[gi] = a[gi*LANE_W +: LANE_W] * b[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // Carry out of bit 31 is intentionally dropped (modulo 2^32).
    assign y = prod[0] + prod[1];

endmodule

// File: rtl/my_ip_v1_0.sv
// AXI4-Stream coprocessor: takes two operand words, returns one dot-product word
// as a single-beat packet.
module my_ip_v1_0
    import myip_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH  = 32,
    parameter int C_M_AXIS_TDATA_WIDTH  = 32,
    parameter int NUMBER_OF_INPUT_WORDS = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    output logic                            S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY
);

    state_t            state_q, state_d;
    logic              cnt_q, cnt_d;
    logic              run_q;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] alu_y;
    logic              s_hs;
    logic              unused_tlast;

    // Job length comes from the word count, so upstream TLAST carries no information.
    assign unused_tlast = S_AXIS_TLAST;

    myip_dot2_alu u_alu (
        .a (a_q),
        .b (b_q),
        .y (alu_y)
    );

    // run_q keeps ready low through reset and for the first edge after release,
    // without any combinational path from ARESETN to the port.
    assign S_AXIS_TREADY = run_q && (state_q == READ_INPUTS);
    assign M_AXIS_TVALID = (state_q == WRITE_OUTPUT);
    assign M_AXIS_TLAST  = (state_q == WRITE_OUTPUT);
    assign M_AXIS_TDATA  = result_q;

    assign s_hs = S_AXIS_TVALID && S_AXIS_TREADY;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        unique case (state_q)
            READ_INPUTS: begin
                if (s_hs) begin
                    if (cnt_q == 1'(NUMBER_OF_INPUT_WORDS - 1)) begin
                        b_d     = S_AXIS_TDATA;
                        cnt_d   = 1'b0;
                        state_d = COMPUTE;
                    end else begin
                        a_d   = S_AXIS_TDATA;
                        cnt_d = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                result_d = alu_y;
                state_d  = WRITE_OUTPUT;
            end
            WRITE_OUTPUT: begin
                if (M_AXIS_TREADY) begin
                    state_d = READ_INPUTS;
                end
            end
            default: begin
                state_d = READ_INPUTS;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESETN) begin
            state_q  <= READ_INPUTS;
            cnt_q    <= 1'b0;
            run_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            run_q    <= 1'b1;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_my_ip_v1_0.sv
// Self-checking bench for my_ip_v1_0: scenario tasks drive jobs, a scoreboard
// queue holds expected results and a negedge monitor compares output beats.
module tb_my_ip_v1_0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int k_edge;

    logic [31:0] exp_q [$];
    int          out_cyc_q [$];

    my_ip_v1_0 dut (
        .ACLK          (clk),
        .ARESETN       (rst),
        .S_AXIS_TREADY (s_tready),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TVALID (s_tvalid),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dot_ref(input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        s = longint'(a[31:16]) * longint'(b[31:16]) + longint'(a[15:0]) * longint'(b[15:0]);
        return s[31:0];
    endfunction

    // Output beats are sampled mid-cycle; the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            logic [31:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got result %08h, required no output", m_tdata);
            end else begin
                e = exp_q.pop_front();
                if (m_tdata !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %08h, required %08h", m_tdata, e);
                end else begin
                    $display("result %08h ok at cycle %0d", m_tdata, cyc);
                end
            end
            n_checks++;
            if (m_tlast !== 1'b1) begin
                n_fail++;
                $display("FAIL sb_tlast: got %b, required 1", m_tlast);
            end
            out_cyc_q.push_back(cyc);
        end
    end

    // Called in the posedge+1 phase; returns in the posedge+1 phase after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        logic hs;
        bit   ok;
        ok       = 0;
        s_tvalid = 1'b1;
        s_tdata  = w;
        for (int i = 0; i < 50; i++) begin
            hs = s_tready;
            @(posedge clk); #1;
            if (hs === 1'b1) begin
                ok = 1;
                break;
            end
        end
        s_tvalid = 1'b0;
        k_edge   = cyc;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: word %08h not accepted, required accept within 50 cycles", w);
        end
    endtask

    task automatic send_job(input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(dot_ref(a, b));
        send_word(a);
        send_word(b);
    endtask

    task automatic wait_drain(input string tag);
        int i;
        for (i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({s_tready, m_tvalid, m_tlast} !== 3'b000 || m_tdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: tready/tvalid/tlast=%b%b%b tdata=%08h, required 000 / 00000000",
                     s_tready, m_tvalid, m_tlast, m_tdata);
        end
        rst = 1'b0;
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tready_early: got %b, required 0", s_tready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tready_release: got %b, required 1", s_tready);
        end
        $display("reset sequence checked");
    endtask

    task automatic test_basic;
        m_tready = 1'b1;
        send_job(32'h00C80264, 32'h0190007B);
        n_checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_compute: tvalid=%b tready=%b, required 0 0", m_tvalid, s_tready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h00025E8C || m_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: tvalid=%b tdata=%08h tlast=%b, required 1 00025e8c 1",
                     m_tvalid, m_tdata, m_tlast);
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pulse: tvalid=%b tready=%b, required 0 1", m_tvalid, s_tready);
        end
        wait_drain("basic");
    endtask

    task automatic test_overflow;
        send_job(32'hFFFFFFFF, 32'hFFFFFFFF);
        n_checks++;
        if (exp_q[0] !== 32'hFFFC0002) begin
            n_fail++;
            $display("FAIL overflow_model: got %08h, required fffc0002", exp_q[0]);
        end
        wait_drain("overflow");
    endtask

    task automatic test_backpressure;
        logic [31:0] d0;
        int i;
        m_tready = 1'b0;
        send_job(32'h12345678, 32'h9ABCDEF0);
        for (i = 0; i < 10 && m_tvalid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        d0 = m_tdata;
        n_checks++;
        if (m_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_timeout: tvalid=%b, required 1", m_tvalid);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || m_tdata !== d0 || s_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: tvalid=%b tlast=%b tdata=%08h s_tready=%b, required 1 1 %08h 0",
                         c, m_tvalid, m_tlast, m_tdata, s_tready, d0);
            end
        end
        m_tready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (m_tvalid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_release: tvalid=%b pending=%0d, required 0 0", m_tvalid, exp_q.size());
        end
        wait_drain("bp");
    endtask

    task automatic test_gaps;
        s_tlast = 1'bx;
        exp_q.push_back(32'h0000000B);
        send_word(32'h00010002);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_hold: s_tready=%b tvalid=%b, required 1 0", s_tready, m_tvalid);
        end
        send_word(32'h00030004);
        wait_drain("gaps");
        s_tlast = 1'b0;
    endtask

    task automatic test_reset_mid;
        send_word(32'h00050005);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({s_tready, m_tvalid, m_tlast} !== 3'b000 || m_tdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: tready/tvalid/tlast=%b%b%b tdata=%08h, required 000 / 00000000",
                     s_tready, m_tvalid, m_tlast, m_tdata);
        end
        rst = 1'b0;
        send_job(32'h00010001, 32'h00020002);
        n_checks++;
        if (exp_q[0] !== 32'h00000004) begin
            n_fail++;
            $display("FAIL midrst_model: got %08h, required 00000004", exp_q[0]);
        end
        wait_drain("midrst");
    endtask

    task automatic test_back_to_back;
        int base;
        base = out_cyc_q.size();
        fork
            begin
                send_job(32'h00070003, 32'h00020009);
                send_job(32'hABCD1234, 32'h00100100);
            end
        join
        wait_drain("b2b");
        n_checks++;
        if (out_cyc_q.size() != base + 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, required 2", out_cyc_q.size() - base);
        end else if (out_cyc_q[base+1] - out_cyc_q[base] != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, required 4",
                     out_cyc_q[base+1] - out_cyc_q[base]);
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_basic;
        test_overflow;
        test_backpressure;
        test_gaps;
        test_reset_mid;
        test_back_to_back;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/my_ip_v1_0.md
# my_ip_v1_0

AXI4-Stream coprocessor computing a 2-lane unsigned 16-bit dot product. It sits between a DMA MM2S channel (slave port) and an S2MM channel (master port). Each job consumes two 32-bit words and returns one 32-bit result word.

## Interface
- C_S_AXIS_TDATA_WIDTH, 32, slave data width; only 32 is supported.
- C_M_AXIS_TDATA_WIDTH, 32, master data width; only 32 is supported.
- NUMBER_OF_INPUT_WORDS, 2, words per job; fixed at 2 (operand A, operand B).
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESETN  in  1  reset. Synchronous, active-high: reset is asserted when ARESETN=1. The codebase name is kept; the polarity and synchronicity are fixed.
- S_AXIS_TREADY  out  1  slave ready.
- S_AXIS_TDATA  in  32  input word {hi[31:16], lo[15:0]}.
- S_AXIS_TLAST  in  1  ignored; the job length is fixed by word count. May be X.
- S_AXIS_TVALID  in  1  slave valid.
- M_AXIS_TVALID  out  1  result valid.
- M_AXIS_TDATA  out  32  result.
- M_AXIS_TLAST  out  1  high with every result word (one-word packets).
- M_AXIS_TREADY  in  1  downstream ready.

## Operation
- **States:** READ_INPUTS, COMPUTE, WRITE_OUTPUT. Reset state is READ_INPUTS.
- **READ_INPUTS**
  - S_AXIS_TREADY=1.
  - On each S_AXIS_TVALID&&S_AXIS_TREADY edge, capture TDATA:
    - 1st word is A = {a1, a0}.
    - 2nd word is B = {b1, b0}.
  - A 1-bit word counter tracks progress. After the 2nd handshake, go to COMPUTE and clear the counter.
- **COMPUTE** (exactly 1 cycle)
  - S_AXIS_TREADY=0.
  - Register result = a1*b1 + a0*b0.
  - Go to WRITE_OUTPUT.
- **WRITE_OUTPUT**
  - M_AXIS_TVALID=1, M_AXIS_TLAST=1, M_AXIS_TDATA=result.
  - S_AXIS_TREADY=0.
  - Hold until M_AXIS_TVALID&&M_AXIS_TREADY, then return to READ_INPUTS.
  - TDATA and TLAST stay stable while stalled.
- **Arithmetic**
  - Lanes are unsigned 16-bit; products are 32-bit.
  - The sum is truncated to 32 bits (modulo 2^32); there is no saturation or overflow flag.
- **Outputs outside WRITE_OUTPUT:** M_AXIS_TVALID=0, M_AXIS_TLAST=0. M_AXIS_TDATA holds the last result (0 after reset).

## Timing
- **Reset (ARESETN=1 at a rising edge)**
  - State goes to READ_INPUTS; counter, A, B and result are cleared to 0.
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
  - S_AXIS_TREADY is forced 0 while ARESETN=1.
  - S_AXIS_TREADY first goes to 1 in the cycle after ARESETN falls.
- **Reset mid-job:** a job in any state is discarded; a partially received A is lost.
- **Latency:** 2nd input accepted at edge k; COMPUTE during cycle k→k+1; M_AXIS_TVALID high after edge k+1. With TREADY=1, the output handshake occurs at edge k+2.
- **Throughput:** with no stalls, one job per 4 cycles (2 read, 1 compute, 1 write).
- **Input gaps:** S_AXIS_TVALID low in READ_INPUTS inserts wait cycles; the counter is held.
- **Back-pressure:** while M_AXIS_TREADY=0, the block stays in WRITE_OUTPUT with S_AXIS_TREADY=0. Upstream data is not lost; it is simply not accepted.
- **Internal back-to-back:** the upstream handshake and the output handshake can never occur in the same cycle.
- **Readiness:** all outputs are driven from registered state; there is no combinational path from any input to any output.

## Structure
- **Package myip_pkg:**
  - state enum {READ_INPUTS, COMPUTE, WRITE_OUTPUT}
  - DATA_W=32, LANE_W=16, N_WORDS=2
- **Sub-module myip_dot2_alu:** purely combinational. Inputs A[31:0], B[31:0]; output the 32-bit truncated a1*b1+a0*b0.
- **Top level:** FSM, word counter, operand and result registers.

## Test plan
- **Basic job:** reset 2 cycles, then send 0x00C80264, 0x0190007B with M_AXIS_TREADY=1.
  - Expect one output 0x00025E8C (200·400 + 612·123 = 155276) with TLAST=1.
  - M_AXIS_TVALID rises 1 cycle after the 2nd handshake edge and is high for exactly 1 cycle.
- **Overflow:** send 0xFFFFFFFF, 0xFFFFFFFF → 0xFFFC0002 (truncated).
- **Back-pressure:** M_AXIS_TREADY=0 for 5 cycles in WRITE_OUTPUT.
  - TVALID, TDATA and TLAST stay stable; S_AXIS_TREADY=0 throughout.
  - The result is released on the first TREADY=1 cycle.
- **Input gaps and TLAST:** S_AXIS_TVALID toggles 1-0-0-1 with words 0x00010002, 0x00030004; S_AXIS_TLAST is X.
  - Result is 0x0000000B; gap cycles are not counted.
- **Reset mid-job:** accept 0x00050005, assert ARESETN=1 for 1 cycle, then send 0x00010001, 0x00020002.
  - Result is 0x00000004; the outputs held their reset values during reset.
- **Back-to-back jobs:** two jobs streamed without gaps → two results, 4 cycles apart, each with TLAST=1.
